morse_receiver: RTL

Receive-side counterpart to the team's Morse transmitter. Samples a serial on/off key line at one sample per symbol period, aligned to mid-symbol from the frame's first rising edge. Captures one 13-symbol frame, matches it against the 8-entry letter table and reports the letter index or a decode error. Sits between a KEY/GPIO input, or the transmitter's LEDR output in loopback, and downstream display logic.

---
 rtl/morse_receiver.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/morse_receiver.sv
// Morse frame receiver: samples key_in mid-symbol, captures 13 symbols, decodes against an 8-letter table.
// Latency: valid/error/letter/pattern update TICK/2 + 12*TICK + 1 cycles after the accepted rising edge.
// No backpressure: valid/error are single-cycle pulses; a new frame can start on the first IDLE cycle after DONE.
module morse_receiver #(
    parameter int TICK = 25000000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        key_in,
    output logic [2:0]  letter,
    output logic        valid,
    output logic        error,
    output logic        busy,
    output logic [12:0] pattern
);

    localparam int TW = $clog2(TICK);
    localparam logic [TW-1:0] HALF_LOAD = TW'(TICK / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(TICK - 1);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          key_m;
    logic          key_s;
    logic          key_p;
    logic [TW-1:0] timer;
    logic [3:0]    bit_cnt;
    logic [12:0]   sr;
    logic          rise;
    logic          sample;
    logic          hit;
    logic [2:0]    hit_idx;

    // Letter table, MSB = first symbol.
    function automatic logic [12:0] table_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    table_entry = 13'b1010000000000;
            3'd1:    table_entry = 13'b1011101110111;
            3'd2:    table_entry = 13'b1110101110000;
            3'd3:    table_entry = 13'b1011101010000;
            3'd4:    table_entry = 13'b1110111000000;
            3'd5:    table_entry = 13'b1110100000000;
            3'd6:    table_entry = 13'b1110111011100;
            default: table_entry = 13'b1011101110100;
        endcase
    endfunction

    assign rise   = key_s & ~key_p;
    assign sample = (state == CAPTURE) && (timer == '0);
    assign busy   = (state != IDLE);

    // Synchronizer and edge-detect delay; reset high so a line already high at release is not an edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
            key_p <= 1'b1;
        end else begin
            key_m <= key_in;
            key_s <= key_m;
            key_p <= key_s;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: edges only matter in IDLE; DONE is a single decode cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (sample && (bit_cnt == 4'd12)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Symbol timer, bit counter and shift register; first sample lands half a symbol after the edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer   <= '0;
            bit_cnt <= '0;
            sr      <= '0;
        end else if ((state == IDLE) && rise) begin
            timer   <= HALF_LOAD;
            bit_cnt <= '0;
        end else if (state == CAPTURE) begin
            if (timer == '0) begin
                sr      <= {sr[11:0], key_s};
                bit_cnt <= bit_cnt + 4'd1;
                timer   <= FULL_LOAD;
            end else begin
                timer <= timer - TW'(1);
            end
        end
    end

    // Table match; entries are distinct so at most one hits.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && (sr == table_entry(3'(i)))) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    // Registered results: pulses last one cycle, letter holds until the next successful decode.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            letter  <= '0;
            valid   <= 1'b0;
            error   <= 1'b0;
            pattern <= '0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (state == DONE) begin
                pattern <= sr;
                if (hit) begin
                    letter <= hit_idx;
                    valid  <= 1'b1;
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule
